// File: rtl/advanced_digital_clock.sv
// Real-time 1 Hz clock with 24/12-hour display, synchronous time load,
// alarm with fixed ring length, and snooze that re-arms a few minutes later.
module advanced_digital_clock #(
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned RING_SEC   = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       switch,
    input  logic       setTime,
    input  logic [5:0] setMin,
    input  logic [4:0] setHrs,
    input  logic       setAM,
    input  logic       setPM,
    input  logic [5:0] alarmmin,
    input  logic [4:0] alarmhr,
    input  logic       alarmAM,
    input  logic       alarmPM,
    input  logic       snooze,
    output logic [5:0] min,
    output logic [4:0] hrs,
    output logic       AM,
    output logic       PM,
    output logic       alarm
);

    localparam int unsigned CW = $clog2(RING_SEC + 1);

    logic [5:0]    sec, mn;
    logic [4:0]    hr;
    logic          ring;
    logic [CW-1:0] ring_cnt;
    logic          snz_pend;
    logic [4:0]    snz_hr;
    logic [5:0]    snz_mn;

    logic [5:0]    nsec, nmn;
    logic [4:0]    nhr;
    logic [5:0]    load_conv, alm_conv;
    logic          alarm_hit, snz_hit;
    logic [6:0]    mn_sum;
    logic [5:0]    tgt_mn;
    logic [4:0]    tgt_hr;

    // Bit 5 = valid, bits 4:0 = hour in 24-hour form.
    function automatic logic [5:0] to24(input logic [4:0] h, input logic am, input logic pm);
        logic [5:0] r;
        r = '0;
        if (am == pm) begin
            if (h <= 5'd23) r = {1'b1, h};
        end else if (h >= 5'd1 && h <= 5'd12) begin
            if (am) r = {1'b1, (h == 5'd12) ? 5'd0 : h};
            else    r = {1'b1, (h == 5'd12) ? 5'd12 : h + 5'd12};
        end
        return r;
    endfunction

    always_comb begin
        load_conv = to24(setHrs, setAM, setPM);
        alm_conv  = to24(alarmhr, alarmAM, alarmPM);

        nsec = sec;
        nmn  = mn;
        nhr  = hr;
        if (setTime) begin
            nsec = '0;
            nmn  = (setMin <= 6'd59) ? setMin : 6'd0;
            nhr  = load_conv[5] ? load_conv[4:0] : 5'd0;
        end else if (sec == 6'd59) begin
            nsec = '0;
            if (mn == 6'd59) begin
                nmn = '0;
                nhr = (hr == 5'd23) ? 5'd0 : hr + 5'd1;
            end else begin
                nmn = mn + 6'd1;
            end
        end else begin
            nsec = sec + 6'd1;
        end

        // Matches are taken against the time being registered this edge, so a load can trigger.
        alarm_hit = alm_conv[5] && (alarmmin <= 6'd59) && (nsec == 6'd0) &&
                    (nmn == alarmmin) && (nhr == alm_conv[4:0]);
        snz_hit   = snz_pend && (nsec == 6'd0) && (nmn == snz_mn) && (nhr == snz_hr);

        mn_sum = {1'b0, mn} + 7'(SNOOZE_MIN);
        tgt_hr = hr;
        tgt_mn = mn_sum[5:0];
        if (mn_sum >= 7'd60) begin
            tgt_mn = 6'(mn_sum - 7'd60);
            tgt_hr = (hr == 5'd23) ? 5'd0 : hr + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec      <= '0;
            mn       <= '0;
            hr       <= '0;
            ring     <= 1'b0;
            ring_cnt <= '0;
            snz_pend <= 1'b0;
            snz_hr   <= '0;
            snz_mn   <= '0;
        end else begin
            sec <= nsec;
            mn  <= nmn;
            hr  <= nhr;
            if (alarm_hit || snz_hit) begin
                ring     <= 1'b1;
                ring_cnt <= '0;
                if (snz_hit) snz_pend <= 1'b0;
            end else if (ring && snooze) begin
                ring     <= 1'b0;
                ring_cnt <= '0;
                snz_pend <= 1'b1;
                snz_hr   <= tgt_hr;
                snz_mn   <= tgt_mn;
            end else if (ring) begin
                if (ring_cnt == CW'(RING_SEC - 1)) begin
                    ring     <= 1'b0;
                    ring_cnt <= '0;
                end else begin
                    ring_cnt <= ring_cnt + CW'(1);
                end
            end
        end
    end

    always_comb begin
        min   = mn;
        alarm = ring;
        hrs   = hr;
        AM    = 1'b0;
        PM    = 1'b0;
        if (switch) begin
            hrs = (hr >= 5'd12) ? hr - 5'd12 : hr;
            if (hrs == 5'd0) hrs = 5'd12;
            AM = (hr < 5'd12);
            PM = ~AM;
        end
    end

endmodule

// File: tb/tb_advanced_digital_clock.sv
// Directed bench: stimulus pushes expected outputs into a queue, a monitor
// process samples the DUT when signalled and compares.
module tb_advanced_digital_clock;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       switch, setTime, setAM, setPM, alarmAM, alarmPM, snooze;
    logic [5:0] setMin, alarmmin;
    logic [4:0] setHrs, alarmhr;
    logic [5:0] min;
    logic [4:0] hrs;
    logic       AM, PM, alarm;

    advanced_digital_clock #(.SNOOZE_MIN(5), .RING_SEC(60)) dut (
        .clk(clk), .rst_n(rst_n), .switch(switch), .setTime(setTime),
        .setMin(setMin), .setHrs(setHrs), .setAM(setAM), .setPM(setPM),
        .alarmmin(alarmmin), .alarmhr(alarmhr), .alarmAM(alarmAM), .alarmPM(alarmPM),
        .snooze(snooze), .min(min), .hrs(hrs), .AM(AM), .PM(PM), .alarm(alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [5:0] mn;
        logic [4:0] hr;
        logic       am;
        logic       pm;
        logic       al;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   fails  = 0;
    event sample_ev;

    task automatic push(input string n, input int m, input int h,
                        input bit a, input bit p, input bit al);
        exp_t e;
        e.name = n;
        e.mn   = 6'(m);
        e.hr   = 5'(h);
        e.am   = a;
        e.pm   = p;
        e.al   = al;
        exp_q.push_back(e);
    endtask

    task automatic check_now();
        -> sample_ev;
        #2;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int h, input int m, input bit a, input bit p);
        setHrs  = 5'(h);
        setMin  = 6'(m);
        setAM   = a;
        setPM   = p;
        setTime = 1'b1;
        tick(1);
        setTime = 1'b0;
    endtask

    // Monitor: samples outputs shortly after each request and drains the queue.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (min !== e.mn || hrs !== e.hr || AM !== e.am || PM !== e.pm || alarm !== e.al) begin
                    fails++;
                    $display("FAIL %s: got min=%0d hrs=%0d AM=%0b PM=%0b alarm=%0b, want min=%0d hrs=%0d AM=%0b PM=%0b alarm=%0b",
                             e.name, min, hrs, AM, PM, alarm, e.mn, e.hr, e.am, e.pm, e.al);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        switch = 0; setTime = 0; setAM = 0; setPM = 0; snooze = 0;
        setMin = 0; setHrs = 0;
        alarmmin = 6'd63; alarmhr = 0; alarmAM = 0; alarmPM = 0;  // alarm disabled
        tick(2);

        // 1: reset and free-running count
        push("reset", 0, 0, 0, 0, 0); check_now();
        rst_n = 1'b1;
        tick(60);
        push("count_60", 1, 0, 0, 0, 0); check_now();
        tick(3540);
        push("count_3600", 0, 1, 0, 0, 0); check_now();

        // 2: 24-hour load, then 12-hour view
        load(13, 25, 0, 0);
        push("load_13_25", 25, 13, 0, 0, 0); check_now();
        tick(60);
        push("load_plus60", 26, 13, 0, 0, 0); check_now();
        switch = 1;
        push("view12_pm", 26, 1, 0, 1, 0); check_now();
        switch = 0;

        // 3: midnight wrap
        load(23, 59, 0, 0);
        tick(60);
        push("wrap24", 0, 0, 0, 0, 0); check_now();
        switch = 1;
        push("wrap12", 0, 12, 1, 0, 0); check_now();
        switch = 0;

        // 4: 12-hour load conversion and invalid values
        load(12, 10, 1, 0);  push("12am", 10, 0, 0, 0, 0);  check_now();
        load(12, 10, 0, 1);  push("12pm", 10, 12, 0, 0, 0); check_now();
        load(3, 7, 0, 1);    push("3pm", 7, 15, 0, 0, 0);   check_now();
        switch = 1;
        push("3pm_view12", 7, 3, 0, 1, 0); check_now();
        switch = 0;
        load(5, 60, 0, 0);   push("min60", 0, 5, 0, 0, 0);   check_now();
        load(0, 30, 1, 0);   push("am_h0", 30, 0, 0, 0, 0);  check_now();
        load(24, 30, 0, 0);  push("h24", 30, 0, 0, 0, 0);    check_now();
        load(7, 8, 1, 1);    push("both_flags", 8, 7, 0, 0, 0); check_now();

        // 5: alarm without snooze, 60-cycle ring
        alarmmin = 24; alarmhr = 11; alarmAM = 1; alarmPM = 0;
        load(11, 23, 1, 0);
        tick(59);
        push("pre_alarm", 23, 11, 0, 0, 0); check_now();
        tick(1);
        push("alarm_rise", 24, 11, 0, 0, 1); check_now();
        tick(59);
        push("ring_last", 24, 11, 0, 0, 1); check_now();
        tick(1);
        push("ring_end", 25, 11, 0, 0, 0); check_now();

        // 6: snooze at 11:24:09, re-ring at 11:29:00
        load(11, 23, 1, 0);
        tick(60);
        push("alarm2_rise", 24, 11, 0, 0, 1); check_now();
        tick(9);
        push("ring_before_snz", 24, 11, 0, 0, 1); check_now();
        snooze = 1;
        tick(1);
        snooze = 0;
        push("snoozed", 24, 11, 0, 0, 0); check_now();
        tick(289);
        push("pre_resnz", 28, 11, 0, 0, 0); check_now();
        tick(1);
        push("snz_rise", 29, 11, 0, 0, 1); check_now();
        tick(3);
        rst_n = 1'b0;
        push("reset_mid_ring", 0, 0, 0, 0, 0); check_now();
        tick(1);
        rst_n = 1'b1;

        // load landing exactly on the alarm time rings on that edge
        load(11, 24, 1, 0);
        push("load_trigger", 24, 11, 0, 0, 1); check_now();

        tick(1);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/advanced_digital_clock.md
Name:
advanced_digital_clock

Overview:
- Real-time digital clock with a 1 Hz `clk` input: seconds, minutes and hours counters.
- Outputs the time in 24-hour or 12-hour format, with AM/PM flags.
- Supports a synchronous time load, a settable alarm, and a 5-minute snooze.
- Top-level timekeeping block that feeds a display driver and a buzzer.

Parameters:
- SNOOZE_MIN, 5, minutes added to the current time when snooze is accepted.
- RING_SEC, 60, maximum number of cycles the alarm output stays high if not snoozed.

Ports:
- clk  input  1  1 Hz clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- switch  input  1  display mode: 0 = 24-hour, 1 = 12-hour.
- setTime  input  1  load request, sampled on rising edge.
- setMin  input  6  minute to load.
- setHrs  input  5  hour to load.
- setAM  input  1  setHrs is a 12-hour AM value.
- setPM  input  1  setHrs is a 12-hour PM value.
- alarmmin  input  6  alarm minute.
- alarmhr  input  5  alarm hour.
- alarmAM  input  1  alarmhr is a 12-hour AM value.
- alarmPM  input  1  alarmhr is a 12-hour PM value.
- snooze  input  1  level; silences a ringing alarm.
- min  output  6  current minute, 0..59.
- hrs  output  5  displayed hour.
- AM  output  1  AM indicator.
- PM  output  1  PM indicator.
- alarm  output  1  alarm ringing.

Behaviour:
- Internal registers:
  - sec (0..59), mn (0..59), hr (0..23, always 24-hour);
  - ring flag, ring counter;
  - snooze-pending flag and snooze target time (hour, minute).
- Reset (rst_n=0, asynchronous): sec=mn=hr=0, ring=0, ring counter=0, snooze-pending=0.
- Timekeeping, each rising edge without setTime:
  - sec increments.
  - sec 59→0 increments mn.
  - mn 59→0 increments hr.
  - hr 23→0.
- Load: setTime=1 at a rising edge loads mn, hr and sec=0 that edge; counting does not advance on that edge. Hour conversion:
  - setAM=setPM=0, or both 1: setHrs taken as 24-hour value.
  - setAM=1, setPM=0: 12→0; 1..11 unchanged.
  - setPM=1, setAM=0: 12→12; 1..11→+12.
  - Invalid values load 0: setMin>59, 24-hour setHrs>23, 12-hour setHrs of 0 or >12.
- Alarm hour uses the same conversion with alarmhr/alarmAM/alarmPM. It is evaluated combinationally from the inputs; invalid values disable the alarm.
- Output mapping is combinational from registers, so a switch change is visible without waiting for an edge.
  - switch=0: hrs=hr, AM=PM=0.
  - switch=1: hrs = hr mod 12, with 0 shown as 12. AM = (hr<12), PM = ~AM.
- min = mn in both modes.
- Alarm trigger: at the edge where the registered time becomes (alarm hour, alarm minute, sec 0), ring is set.
  - The snooze target time with snooze-pending=1 also triggers ring; snooze-pending clears at that trigger.
  - A trigger caused by a setTime load counts.
- Ringing: alarm=ring. The ring counter increments each edge while ringing; ring clears after RING_SEC cycles.
- Snooze: snooze=1 sampled at a rising edge while ring=1 does the following on that edge:
  - ring clears;
  - snooze-pending is set;
  - snooze target = current hr:mn + SNOOZE_MIN, with minute and hour wrap.
- snooze=1 while not ringing has no effect. A held snooze therefore gives a 1-cycle ring every 5 minutes.
- A new alarm-time match while already ringing restarts the ring counter.
- Reset mid-ring clears ring and snooze-pending immediately.

Test Plan:
1. Reset, switch=0, no setTime.
   - Required: min=0, hrs=0, AM=PM=0.
   - After 60 edges: min=1. After 3600 edges: hrs=1, min=0.
2. setTime pulse for one edge with setHrs=13, setMin=25, setAM=setPM=0, switch=0.
   - Required: next edge gives hrs=13, min=25.
   - 60 edges later: min=26.
   - Then switch=1: hrs=1, PM=1, AM=0 immediately.
3. Load 23:59 (24-hour), wait 60 edges.
   - Required: hrs=0, min=0.
   - With switch=1: hrs=12, AM=1, PM=0.
4. 12-hour load conversion.
   - setHrs=12, setAM=1: 24-hour hrs=0.
   - setHrs=12, setPM=1: hrs=12.
   - setHrs=3, setPM=1: hrs=15.
   - setMin=60: min=0.
5. Alarm without snooze: alarm 11:24 with alarmAM=1, load 11:23 with setAM=1, snooze=0.
   - Required: alarm rises after 60 edges and stays high exactly 60 cycles.
6. Alarm with snooze: same setup, snooze=1 pulsed 10 edges into the ring.
   - Required: alarm=0 after that edge.
   - alarm re-rises when time reaches 11:29:00 (the snooze was taken at 11:24).
   - Reset during a ring: alarm=0 immediately.
